// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM states, frame geometry, parity helper and
// common keyboard command bytes.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    SHIFT,
    WAIT_IDLE
  } ps2_state_e;

  localparam int PS2_FRAME_BITS = 11;
  localparam int PS2_ACK_BIT    = 11;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;

  // PS/2 uses odd parity: the parity bit makes the total count of ones odd.
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Synchronizes one asynchronous PS/2 line and flags its falling edges.
// Latency: STAGES cycles to sync, fall is combinational from the last two synced samples.
// Backpressure: none; free-running, one fall flag per low phase of the line.
module ps2_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic core_clk,
  input  logic arst_n,
  input  logic din,
  output logic sync,
  output logic fall
);

  logic [STAGES-1:0] pipe_q;
  logic              prev_q;

  // Idle PS/2 lines are pulled up, so every stage resets to 1 to avoid a false fall.
  always_ff @(posedge core_clk or negedge arst_n) begin
    if (!arst_n) begin
      pipe_q <= '1;
      prev_q <= 1'b1;
    end else begin
      pipe_q[0] <= din;
      for (int i = 1; i < STAGES; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
      prev_q <= pipe_q[STAGES-1];
    end
  end

  assign sync = pipe_q[STAGES-1];
  assign fall = prev_q & ~pipe_q[STAGES-1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, 11-clock frame, ACK check.
// Latency: INHIBIT_CYCLES + one device frame; line drives update one cycle after a detected fall.
// Backpressure: tx_ready only in IDLE; tx_valid while busy is ignored, not queued.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  output logic       busy,
  output logic       done,
  output logic       err_noack,
  output logic       err_timeout
);

  localparam int INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [INH_W-1:0] INH_LAST   = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [WD_W-1:0]  WD_LAST    = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]       BIT_DATA7  = 4'd8;
  localparam logic [3:0]       BIT_PARITY = 4'd9;
  localparam logic [3:0]       BIT_STOP   = 4'(PS2_FRAME_BITS - 1);
  localparam logic [3:0]       BIT_ACK    = 4'(PS2_ACK_BIT);

  logic clk_sync;
  logic clk_fall;
  logic data_sync;
  logic data_fall_unused;

  ps2_state_e       state_q,  state_d;
  logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
  logic [WD_W-1:0]  wd_q,     wd_d;
  logic [3:0]       bitcnt_q, bitcnt_d;
  logic [7:0]       shift_q,  shift_d;
  logic             par_q,    par_d;
  logic             clk_oe_d;
  logic             data_oe_d;
  logic             done_d;
  logic             noack_d;
  logic             timeout_d;
  logic             wd_active;

  ps2_sync_edge #(.STAGES(SYNC_STAGES)) u_clk_sync (
    .core_clk (clk),
    .arst_n   (rst),
    .din      (ps2_clk_i),
    .sync     (clk_sync),
    .fall     (clk_fall)
  );

  ps2_sync_edge #(.STAGES(SYNC_STAGES)) u_data_sync (
    .core_clk (clk),
    .arst_n   (rst),
    .din      (ps2_data_i),
    .sync     (data_sync),
    .fall     (data_fall_unused)
  );

  assign wd_active = (state_q == REQ) || (state_q == SHIFT) || (state_q == WAIT_IDLE);

  always_comb begin
    state_d   = state_q;
    inh_cnt_d = inh_cnt_q;
    wd_d      = wd_q;
    bitcnt_d  = bitcnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    clk_oe_d  = 1'b0;
    data_oe_d = ps2_data_oe;
    done_d    = 1'b0;
    noack_d   = 1'b0;
    timeout_d = 1'b0;

    case (state_q)
      IDLE: begin
        data_oe_d = 1'b0;
        if (tx_valid && tx_ready) begin
          shift_d   = tx_data;
          par_d     = odd_parity(tx_data);
          inh_cnt_d = '0;
          state_d   = INHIBIT;
          clk_oe_d  = 1'b1;
          data_oe_d = (INHIBIT_CYCLES == 1);
        end
      end

      INHIBIT: begin
        if (inh_cnt_q == INH_LAST) begin
          // Release the clock with data already low: that is the request-to-send.
          state_d   = REQ;
          data_oe_d = 1'b1;
          wd_d      = '0;
          bitcnt_d  = '0;
        end else begin
          inh_cnt_d = inh_cnt_q + 1'b1;
          clk_oe_d  = 1'b1;
          data_oe_d = (inh_cnt_d == INH_LAST);
        end
      end

      REQ: begin
        data_oe_d = 1'b1;
        bitcnt_d  = '0;
        wd_d      = clk_fall ? '0 : wd_q + 1'b1;
        state_d   = SHIFT;
      end

      SHIFT: begin
        if (clk_fall) begin
          wd_d     = '0;
          bitcnt_d = (bitcnt_q == BIT_ACK) ? bitcnt_q : bitcnt_q + 4'd1;
          if (bitcnt_d <= BIT_DATA7) begin
            data_oe_d = ~shift_q[0];
            shift_d   = shift_q >> 1;
          end else if (bitcnt_d == BIT_PARITY) begin
            data_oe_d = ~par_q;
          end else if (bitcnt_d == BIT_STOP) begin
            data_oe_d = 1'b0;
          end else begin
            data_oe_d = 1'b0;
            if (data_sync) begin
              noack_d = 1'b1;
              state_d = IDLE;
            end else begin
              state_d = WAIT_IDLE;
            end
          end
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end

      WAIT_IDLE: begin
        data_oe_d = 1'b0;
        wd_d      = clk_fall ? '0 : wd_q + 1'b1;
        if (clk_sync && data_sync) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end

      default: begin
        state_d   = IDLE;
        data_oe_d = 1'b0;
      end
    endcase

    // A live device clock always restarts the watchdog, so a fall wins over expiry.
    if (wd_active && !clk_fall && (wd_q == WD_LAST)) begin
      state_d   = IDLE;
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
      done_d    = 1'b0;
      noack_d   = 1'b0;
      timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      inh_cnt_q   <= '0;
      wd_q        <= '0;
      bitcnt_q    <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      tx_ready    <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      err_noack   <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state_q     <= state_d;
      inh_cnt_q   <= inh_cnt_d;
      wd_q        <= wd_d;
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      ps2_clk_oe  <= clk_oe_d;
      ps2_data_oe <= data_oe_d;
      tx_ready    <= (state_d == IDLE);
      busy        <= (state_d != IDLE);
      done        <= done_d;
      err_noack   <= noack_d;
      err_timeout <= timeout_d;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus with a PS/2 device model, frame model from byte
// arithmetic, and a per-cycle monitor scoring outputs against the expected outcome queue.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH  = 30;
  localparam int TMO  = 120;
  localparam int HALF = 8;

  localparam int O_DONE  = 1;
  localparam int O_NOACK = 2;
  localparam int O_TMO   = 3;

  // Frame on the wire, index 0 = start bit ... 10 = stop bit.
  localparam logic [10:0] ED_FRAME = {1'b1, 1'b1, 8'b1110_1101, 1'b0};
  localparam logic [10:0] F4_FRAME = {1'b1, 1'b0, 8'b1111_0100, 1'b0};

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, err_noack, err_timeout;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       ps2_clk_i, ps2_data_i;

  assign ps2_clk_i  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_i = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TMO),
    .SYNC_STAGES    (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .ps2_clk_i   (ps2_clk_i),
    .ps2_data_i  (ps2_data_i),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe),
    .busy        (busy),
    .done        (done),
    .err_noack   (err_noack),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_q[$];
  int exp_outcome = O_DONE;
  int n_done = 0, n_noack = 0, n_tmo = 0, n_accept = 0;
  int cyc = 0, hi_run = 0, req_cnt = 0, req_cyc = 0, tmo_cyc = 0;
  logic clk_oe_prev = 1'b0;
  logic [10:0] bits;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Wire image of a byte: start 0, data LSB first, parity makes the ones count odd, stop 1.
  function automatic logic [10:0] model_frame(input logic [7:0] b);
    logic [10:0] m;
    m[0]   = 1'b0;
    m[8:1] = b;
    m[9]   = (($countones(b) % 2) == 0);
    m[10]  = 1'b1;
    return m;
  endfunction

  // Per-cycle monitor.
  initial forever begin
    int code;
    @(negedge clk);
    cyc++;
    if (!rst) begin
      exp_q.delete();
      hi_run      = 0;
      clk_oe_prev = 1'b0;
    end else begin
      chk("ready_vs_busy", tx_ready, !busy);
      if (!busy) chk("idle_lines_released", {ps2_clk_oe, ps2_data_oe}, 0);
      chk("pulses_exclusive", ($countones({done, err_noack, err_timeout}) <= 1), 1);
      if (done || err_noack || err_timeout) begin
        code = done ? O_DONE : (err_noack ? O_NOACK : O_TMO);
        if (exp_q.size() == 0) chk("pulse_unexpected", code, 0);
        else chk("outcome", code, exp_q.pop_front());
        if (done) n_done++;
        if (err_noack) n_noack++;
        if (err_timeout) begin
          n_tmo++;
          tmo_cyc = cyc;
        end
      end
      if (ps2_clk_oe) begin
        hi_run++;
      end else if (clk_oe_prev) begin
        chk("inhibit_len_min", (hi_run >= INH), 1);
        chk("start_bit_driven", ps2_data_oe, 1);
        hi_run  = 0;
        req_cnt++;
        req_cyc = cyc;
      end
      clk_oe_prev = ps2_clk_oe;
      if (tx_valid && tx_ready) begin
        exp_q.push_back(exp_outcome);
        n_accept++;
      end
    end
  end

  task automatic send(input logic [7:0] b, input int outcome, input bit hold);
    int t;
    exp_outcome = outcome;
    @(posedge clk); #1;
    tx_data  = b;
    tx_valid = 1'b1;
    t = 0;
    do begin
      @(posedge clk); #1;
      t++;
    end while (tx_ready && t < 20);
    chk("accept", !tx_ready, 1);
    if (hold) tx_data = 8'h00;
    else tx_valid = 1'b0;
  endtask

  // Device: waits for request-to-send, clocks nfalls pulses, reads data at each rising edge.
  task automatic dev_frame(input int nfalls, input bit ack, output logic [10:0] fb);
    int t;
    fb = '1;
    t = 0;
    while (!(ps2_clk_i && !ps2_data_i) && t < 4 * INH + 100) begin
      @(posedge clk); #1;
      t++;
    end
    chk("dev_request_seen", (t < 4 * INH + 100), 1);
    if (t >= 4 * INH + 100) return;
    fb[0] = ps2_data_i;
    repeat (HALF) @(posedge clk);
    #1;
    for (int i = 1; i <= nfalls; i++) begin
      dev_clk_low = 1'b1;
      repeat (HALF) @(posedge clk);
      #1;
      if (i <= 10) fb[i] = ps2_data_i;
      dev_clk_low = 1'b0;
      if (i == 10 && ack) begin
        repeat (2) @(posedge clk);
        #1;
        dev_data_low = 1'b1;
      end
      if (i == 11) dev_data_low = 1'b0;
      repeat (HALF) @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_outcome(input int prev_total);
    int t;
    t = 0;
    while ((n_done + n_noack + n_tmo) == prev_total && t < TMO + 100) begin
      @(posedge clk); #1;
      t++;
    end
    chk("outcome_within_bound", (t < TMO + 100), 1);
  endtask

  task automatic run_done(input logic [7:0] b, input logic [10:0] lit, input string tag);
    int d0, tot0;
    d0   = n_done;
    tot0 = n_done + n_noack + n_tmo;
    send(b, O_DONE, 1'b0);
    dev_frame(11, 1'b1, bits);
    wait_outcome(tot0);
    chk({tag, "_frame_literal"}, bits, lit);
    chk({tag, "_frame_model"}, bits, model_frame(b));
    chk({tag, "_done_once"}, n_done - d0, 1);
    chk({tag, "_ready_back"}, tx_ready, 1);
    chk({tag, "_lines_released"}, {ps2_clk_oe, ps2_data_oe}, 0);
  endtask

  initial begin
    int d0, a0, nk0, tot0, r0, p0;
    logic [10:0] mf;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_tx_ready", tx_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_oe", {ps2_clk_oe, ps2_data_oe}, 0);
    chk("reset_pulses", {done, err_noack, err_timeout}, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (5) @(posedge clk);

    // Set-LEDs command, device acknowledges.
    run_done(PS2_CMD_SET_LEDS, ED_FRAME, "ed");

    // Enable command while a 0x00 request is held during the whole busy period.
    d0   = n_done;
    a0   = n_accept;
    tot0 = n_done + n_noack + n_tmo;
    send(PS2_CMD_ENABLE, O_DONE, 1'b1);
    fork
      dev_frame(11, 1'b1, bits);
      begin
        repeat (INH + 8 * 2 * HALF) @(posedge clk);
        #1;
        chk("hold_still_busy", busy, 1);
        tx_valid = 1'b0;
      end
    join
    wait_outcome(tot0);
    chk("f4_frame_literal", bits, F4_FRAME);
    chk("f4_frame_model", bits, model_frame(PS2_CMD_ENABLE));
    chk("f4_done_once", n_done - d0, 1);
    repeat (20) @(posedge clk);
    #1;
    chk("f4_single_accept", n_accept - a0, 1);
    chk("f4_queue_drained", exp_q.size(), 0);

    // Device leaves data high at the ACK clock.
    d0   = n_done;
    nk0  = n_noack;
    tot0 = n_done + n_noack + n_tmo;
    send(PS2_CMD_RESET, O_NOACK, 1'b0);
    dev_frame(11, 1'b0, bits);
    wait_outcome(tot0);
    chk("noack_frame_model", bits, model_frame(PS2_CMD_RESET));
    chk("noack_pulse_once", n_noack - nk0, 1);
    chk("noack_no_done", n_done - d0, 0);
    chk("noack_lines_released", {ps2_clk_oe, ps2_data_oe}, 0);

    // Device never clocks after the request.
    d0   = n_done;
    r0   = req_cnt;
    tot0 = n_done + n_noack + n_tmo;
    send(PS2_CMD_SET_LEDS, O_TMO, 1'b0);
    begin
      int t;
      t = 0;
      while (req_cnt == r0 && t < INH + 50) begin
        @(posedge clk); #1;
        t++;
      end
      chk("tmo_request_seen", (req_cnt != r0), 1);
    end
    wait_outcome(tot0);
    chk("tmo_latency", tmo_cyc - req_cyc, TMO);
    chk("tmo_lines_released", {ps2_clk_oe, ps2_data_oe}, 0);
    chk("tmo_no_done", n_done - d0, 0);

    // Reset in the middle of a 0xFF frame.
    send(PS2_CMD_RESET, O_DONE, 1'b0);
    dev_frame(5, 1'b1, bits);
    mf = model_frame(PS2_CMD_RESET);
    chk("rst_partial_bits", bits[5:0], mf[5:0]);
    chk("rst_pre_busy", busy, 1);
    p0 = n_done + n_noack + n_tmo;
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("rst_oe_released", {ps2_clk_oe, ps2_data_oe}, 0);
    chk("rst_busy_cleared", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    chk("rst_no_pulses", (n_done + n_noack + n_tmo) - p0, 0);

    // Normal frame after the aborted one.
    run_done(PS2_CMD_SET_LEDS, ED_FRAME, "ed_after_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL global_time_limit: simulation still running at %0t, expected finish earlier", $time);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "time limit");
  end

endmodule
